// File: rtl/hkspi_pt_pkg.sv
// Shared types and helpers for the housekeeping-SPI pass-thru bridge.
//   state_e      : bridge FSM states
//   PT_CHAN_W    : width of the downstream channel index
//   chan_opcode  : first-byte opcode that selects downstream channel k
package hkspi_pt_pkg;

    localparam int PT_CHAN_W = 3;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CMD      = 3'd1,
        PASS     = 3'd2,
        IGNORE   = 3'd3,
        RELEASE  = 3'd4,
        WAIT_CSB = 3'd5
    } state_e;

    // Channel opcodes sit on even steps above the base opcode.
    function automatic logic [7:0] chan_opcode(input logic [7:0] base, input int unsigned k);
        return base + 8'(k << 1);
    endfunction

endpackage

// File: rtl/hkspi_pt_sync.sv
// Two-flop synchroniser with registered edge pulses.
//   clk_i   : core clock
//   rst_i   : asynchronous reset, active-high
//   d_i     : asynchronous input
//   q_o     : synchronised level
//   rise_o  : one-clock pulse, one clock after q_o rises
//   fall_o  : one-clock pulse, one clock after q_o falls
// RST_VAL sets the idle level so that reset release never looks like an edge.
module hkspi_pt_sync #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;
    logic rise_q;
    logic fall_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
            prev_q <= RST_VAL;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
            rise_q <= sync_q & ~prev_q;
            fall_q <= ~sync_q & prev_q;
        end
    end

    assign q_o    = sync_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/hkspi_passthru_bridge.sv
// Multi-channel housekeeping-SPI pass-thru bridge, oversampled on the core clock.
// The first byte of each host transaction either opens a pass-thru session to one
// downstream SPI flash (opcode CMD_BASE+2k) or is handed to the register decoder
// as cmd_byte with a one-clock cmd_valid pulse.
// Ports:
//   clock, reset            : core clock, asynchronous active-high reset
//   hk_csb/hk_sck/hk_sdi    : host pads (asynchronous)
//   hk_sdo, hk_sdo_oe       : host data out and its drive enable
//   pt_csb, pt_sck, pt_mosi : downstream flash chip selects / clock / data out
//   pt_miso                 : downstream flash data in, one per channel
//   cpu_hold                : holds the management CPU in reset during selected sessions
//   pt_active, pt_chan      : session in progress, selected channel
//   cmd_valid, cmd_byte     : non-pass-thru first byte
//   pt_timeout              : sticky, last session force-released on idle SCK
// Optional feature macro: HKSPI_PT_TIMEOUT_EN enables the idle-SCK forced release
// (TIMEOUT_CYC clocks) and the WAIT_CSB state. Without it pt_timeout is tied low.
module hkspi_passthru_bridge
    import hkspi_pt_pkg::*;
#(
    parameter int                  NUM_CHAN    = 2,
    parameter logic [7:0]          CMD_BASE    = 8'hC2,
    parameter logic [NUM_CHAN-1:0] HOLD_MASK   = 2'b10,
    parameter int                  TIMEOUT_CYC = 65535
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 hk_csb,
    input  logic                 hk_sck,
    input  logic                 hk_sdi,
    output logic                 hk_sdo,
    output logic                 hk_sdo_oe,
    output logic [NUM_CHAN-1:0]  pt_csb,
    output logic                 pt_sck,
    output logic                 pt_mosi,
    input  logic [NUM_CHAN-1:0]  pt_miso,
    output logic                 cpu_hold,
    output logic                 pt_active,
    output logic [PT_CHAN_W-1:0] pt_chan,
    output logic                 cmd_valid,
    output logic [7:0]           cmd_byte,
    output logic                 pt_timeout
);

    logic csb_lvl, csb_rise, csb_fall;
    logic sck_lvl, sck_rise, sck_fall;
    logic sdi_lvl, sdi_rise, sdi_fall;
    logic miso_mux, miso_lvl, miso_rise, miso_fall;

    hkspi_pt_sync #(.RST_VAL(1'b1)) u_sync_csb (
        .clk_i(clock), .rst_i(reset), .d_i(hk_csb),
        .q_o(csb_lvl), .rise_o(csb_rise), .fall_o(csb_fall)
    );
    hkspi_pt_sync #(.RST_VAL(1'b0)) u_sync_sck (
        .clk_i(clock), .rst_i(reset), .d_i(hk_sck),
        .q_o(sck_lvl), .rise_o(sck_rise), .fall_o(sck_fall)
    );
    hkspi_pt_sync #(.RST_VAL(1'b0)) u_sync_sdi (
        .clk_i(clock), .rst_i(reset), .d_i(hk_sdi),
        .q_o(sdi_lvl), .rise_o(sdi_rise), .fall_o(sdi_fall)
    );
    hkspi_pt_sync #(.RST_VAL(1'b0)) u_sync_miso (
        .clk_i(clock), .rst_i(reset), .d_i(miso_mux),
        .q_o(miso_lvl), .rise_o(miso_rise), .fall_o(miso_fall)
    );

    state_e               state_q;
    logic [2:0]           bit_cnt_q;
    logic [7:0]           shift_q;
    logic [7:0]           shift_d;
    logic                 sck_en_q;
    logic                 hk_sdo_q;
    logic                 hk_sdo_oe_q;
    logic [NUM_CHAN-1:0]  pt_csb_q;
    logic                 pt_sck_q;
    logic                 pt_mosi_q;
    logic                 cpu_hold_q;
    logic                 pt_active_q;
    logic [PT_CHAN_W-1:0] pt_chan_q;
    logic                 cmd_valid_q;
    logic [7:0]           cmd_byte_q;
    logic                 timeout_hit;

    // Byte as it will look once the current SDI bit is shifted in.
    assign shift_d = {shift_q[6:0], sdi_lvl};

    logic [NUM_CHAN-1:0]  hit_vec;
    logic                 hit;
    logic [PT_CHAN_W-1:0] hit_idx;
    logic                 hit_hold;
    logic [NUM_CHAN-1:0]  hit_csb;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CHAN; gi++) begin : g_opcode
            assign hit_vec[gi] = (shift_d == chan_opcode(CMD_BASE, gi));
        end
    endgenerate

    assign hit = |hit_vec;

    // Opcodes are distinct, so at most one channel matches.
    always_comb begin
        hit_idx  = '0;
        hit_hold = 1'b0;
        hit_csb  = '1;
        for (int k = 0; k < NUM_CHAN; k++) begin
            if (hit_vec[k]) begin
                hit_idx    = PT_CHAN_W'(k);
                hit_hold   = HOLD_MASK[k];
                hit_csb[k] = 1'b0;
            end
        end
    end

    always_comb begin
        miso_mux = 1'b0;
        for (int k = 0; k < NUM_CHAN; k++) begin
            if (pt_chan_q == PT_CHAN_W'(k)) begin
                miso_mux = pt_miso[k];
            end
        end
    end

`ifdef HKSPI_PT_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] idle_cnt_q;
    logic             pt_timeout_q;

    // A CSB rise on the same clock wins: that is an ordinary release.
    assign timeout_hit = (idle_cnt_q == CNT_W'(TIMEOUT_CYC - 1)) && !csb_rise;
    assign pt_timeout  = pt_timeout_q;

    logic unused_ok;
    assign unused_ok = &{1'b0, sdi_rise, sdi_fall, miso_rise, miso_fall};
`else
    assign timeout_hit = 1'b0;
    assign pt_timeout  = 1'b0;

    logic unused_ok;
    assign unused_ok = &{1'b0, sdi_rise, sdi_fall, miso_rise, miso_fall, TIMEOUT_CYC[0]};
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            sck_en_q    <= 1'b0;
            hk_sdo_q    <= 1'b0;
            hk_sdo_oe_q <= 1'b0;
            pt_csb_q    <= '1;
            pt_sck_q    <= 1'b0;
            pt_mosi_q   <= 1'b0;
            cpu_hold_q  <= 1'b0;
            pt_active_q <= 1'b0;
            pt_chan_q   <= '0;
            cmd_valid_q <= 1'b0;
            cmd_byte_q  <= '0;
`ifdef HKSPI_PT_TIMEOUT_EN
            idle_cnt_q   <= '0;
            pt_timeout_q <= 1'b0;
`endif
        end else begin
            cmd_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (csb_fall) begin
                        state_q   <= CMD;
                        bit_cnt_q <= '0;
`ifdef HKSPI_PT_TIMEOUT_EN
                        pt_timeout_q <= 1'b0;
`endif
                    end
                end
                CMD: begin
                    if (csb_rise) begin
                        state_q <= IDLE;
                    end else if (sck_rise) begin
                        shift_q   <= shift_d;
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            if (hit) begin
                                state_q     <= PASS;
                                pt_chan_q   <= hit_idx;
                                pt_csb_q    <= hit_csb;
                                pt_active_q <= 1'b1;
                                cpu_hold_q  <= hit_hold;
                                hk_sdo_oe_q <= 1'b1;
                                // SCK is still high from the opcode's last bit; hold
                                // the flash clock low until the host drops it.
                                sck_en_q    <= 1'b0;
`ifdef HKSPI_PT_TIMEOUT_EN
                                idle_cnt_q  <= '0;
`endif
                            end else begin
                                state_q     <= IGNORE;
                                cmd_valid_q <= 1'b1;
                                cmd_byte_q  <= shift_d;
                            end
                        end
                    end
                end
                PASS: begin
                    pt_mosi_q <= sdi_lvl;
                    pt_sck_q  <= sck_lvl & sck_en_q;
                    hk_sdo_q  <= miso_lvl;
                    if (sck_fall) begin
                        sck_en_q <= 1'b1;
                    end
`ifdef HKSPI_PT_TIMEOUT_EN
                    if (sck_rise || sck_fall) begin
                        idle_cnt_q <= '0;
                    end else begin
                        idle_cnt_q <= idle_cnt_q + CNT_W'(1);
                    end
`endif
                    if (csb_rise || timeout_hit) begin
                        state_q     <= RELEASE;
                        pt_csb_q    <= '1;
                        pt_sck_q    <= 1'b0;
                        pt_mosi_q   <= 1'b0;
                        hk_sdo_q    <= 1'b0;
                        hk_sdo_oe_q <= 1'b0;
`ifdef HKSPI_PT_TIMEOUT_EN
                        if (timeout_hit) begin
                            pt_timeout_q <= 1'b1;
                        end
`endif
                    end
                end
                IGNORE: begin
                    if (csb_lvl) begin
                        state_q <= IDLE;
                    end
                end
                RELEASE: begin
                    pt_active_q <= 1'b0;
                    cpu_hold_q  <= 1'b0;
`ifdef HKSPI_PT_TIMEOUT_EN
                    // After a forced release the host is still mid-transfer.
                    state_q <= pt_timeout_q ? WAIT_CSB : IDLE;
`else
                    state_q <= IDLE;
`endif
                end
`ifdef HKSPI_PT_TIMEOUT_EN
                WAIT_CSB: begin
                    if (csb_lvl) begin
                        state_q <= IDLE;
                    end
                end
`endif
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign hk_sdo    = hk_sdo_q;
    assign hk_sdo_oe = hk_sdo_oe_q;
    assign pt_csb    = pt_csb_q;
    assign pt_sck    = pt_sck_q;
    assign pt_mosi   = pt_mosi_q;
    assign cpu_hold  = cpu_hold_q;
    assign pt_active = pt_active_q;
    assign pt_chan   = pt_chan_q;
    assign cmd_valid = cmd_valid_q;
    assign cmd_byte  = cmd_byte_q;

endmodule
